// File: rtl/mod_mult_pkg.sv
// Shared definitions for the modular multiplier family: default datapath width
// and the exponentiation sequencer state encoding.
package mod_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    SQ_ISS  = 3'd2,
    SQ_WAIT = 3'd3,
    MU_ISS  = 3'd4,
    MU_WAIT = 3'd5,
    NEXT    = 3'd6,
    FIN     = 3'd7
  } state_t;

endpackage

// File: rtl/mme_bit_counter.sv
// Exponent bit scanner: loadable down-counter selecting exp_val[i], MSB first.
module mme_bit_counter #(
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] exp_val,
  output logic                 is_zero_c,
  output logic                 bit_out_c
);

  localparam int unsigned CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] TOP = CW'(EXP_WIDTH - 1);

  logic [CW-1:0] cnt_q;

  // Saturates at zero so a stray decrement can never wrap the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TOP;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign is_zero_c = (cnt_q == '0);
  assign bit_out_c = exp_val[cnt_q];

endmodule

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer: issues one A*B mod N job at a time
// to the modular multiplier and holds BASE^EXP mod N.
module mod_exp_sequencer
  import mod_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_product
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic                 armed_q, armed_d;
  logic                 busy_d, done_d, err_d, mm_start_d;
  logic [WIDTH-1:0]     result_d, mm_a_d, mm_b_d, mm_n_d;
  logic                 cnt_load, cnt_dec, cnt_zero, cnt_bit;

  mme_bit_counter #(.EXP_WIDTH(EXP_WIDTH)) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .exp_val   (exp_q),
    .is_zero_c (cnt_zero),
    .bit_out_c (cnt_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      r_q      <= '0;
      armed_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_n     <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      r_q      <= r_d;
      armed_q  <= armed_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      result   <= result_d;
      mm_start <= mm_start_d;
      mm_a     <= mm_a_d;
      mm_b     <= mm_b_d;
      mm_n     <= mm_n_d;
    end
  end

  // Next-state and registered-output computation; outputs reflect the state entered.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    r_d        = r_q;
    armed_d    = armed_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    result_d   = result;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a;
    mm_b_d     = mm_b;
    mm_n_d     = mm_n;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base;
          exp_d    = exponent;
          mm_n_d   = modulus;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if ((mm_n == '0) || (base_q >= mm_n)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = FIN;
        end else if (mm_n == WIDTH'(1)) begin
          result_d = '0;
          state_d  = FIN;
        end else if (exp_q == '0) begin
          result_d = WIDTH'(1);
          state_d  = FIN;
        end else begin
          r_d      = WIDTH'(1);
          cnt_load = 1'b1;
          state_d  = SQ_ISS;
        end
      end
      SQ_ISS: begin
        mm_a_d     = r_q;
        mm_b_d     = r_q;
        mm_start_d = 1'b1;
        armed_d    = 1'b0;
        state_d    = SQ_WAIT;
      end
      // A done level is only trusted after it has been seen low for this job.
      SQ_WAIT: begin
        if (!mm_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          r_d     = mm_product;
          state_d = cnt_bit ? MU_ISS : NEXT;
        end
      end
      MU_ISS: begin
        mm_a_d     = r_q;
        mm_b_d     = base_q;
        mm_start_d = 1'b1;
        armed_d    = 1'b0;
        state_d    = MU_WAIT;
      end
      MU_WAIT: begin
        if (!mm_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          r_d     = mm_product;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (cnt_zero) begin
          result_d = r_q;
          state_d  = FIN;
        end else begin
          cnt_dec = 1'b1;
          state_d = SQ_ISS;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Randomized self-checking bench for mod_exp_sequencer with a behavioural
// multiplier model and an arithmetic reference for BASE^EXP mod N.
module tb_mod_exp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base, exponent, modulus;
  logic       busy, done, err;
  logic [7:0] result;
  logic       mm_start;
  logic [7:0] mm_a, mm_b, mm_n;
  logic       mm_done;
  logic [7:0] mm_product;

  int checks = 0;
  int errors = 0;

  // Multiplier model state
  int mm_pulses = 0;
  int overlaps  = 0;
  int fixed_lat = 0;
  bit stale_mode = 1'b0;
  int low_cnt, stale_cnt, lat_pend;
  logic [7:0] prod_q;

  always #5 clk = ~clk;

  mod_exp_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_product(mm_product)
  );

  // Multiplier: Done drops after a start (or after a stale hold), rises after latency.
  always @(posedge clk or posedge rst) begin
    int lat_v;
    if (rst) begin
      mm_done    <= 1'b1;
      mm_product <= 8'h00;
      low_cnt    <= 0;
      stale_cnt  <= 0;
      lat_pend   <= 0;
    end else if (mm_start) begin
      lat_v = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 40));
      mm_pulses  <= mm_pulses + 1;
      if (low_cnt != 0 || stale_cnt != 0) overlaps <= overlaps + 1;
      prod_q     <= 8'((int'(mm_a) * int'(mm_b)) % int'(mm_n));
      mm_product <= 8'hFF;
      if (stale_mode) begin
        stale_cnt <= 5;
        lat_pend  <= lat_v;
      end else begin
        mm_done <= 1'b0;
        low_cnt <= lat_v;
      end
    end else if (stale_cnt == 1) begin
      stale_cnt <= 0;
      mm_done   <= 1'b0;
      low_cnt   <= lat_pend;
    end else if (stale_cnt > 1) begin
      stale_cnt <= stale_cnt - 1;
    end else if (low_cnt == 1) begin
      low_cnt    <= 0;
      mm_done    <= 1'b1;
      mm_product <= prod_q;
    end else if (low_cnt > 1) begin
      low_cnt <= low_cnt - 1;
    end
  end

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: plain repeated multiplication.
  function automatic int ref_exp(input int b, input int e, input int n, output int er);
    int r;
    er = 0;
    if (n == 0 || b >= n) begin
      er = 1;
      return 0;
    end
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * b) % n;
    return r;
  endfunction

  task automatic run_op(input int b, input int e, input int n, input bit hold_start,
                        output int res, output int er, output int lat, output int jobs,
                        output int dones, output int busy_after);
    int p0, cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; base = 8'(b); exponent = 8'(e); modulus = 8'(n);
    p0 = mm_pulses;
    @(negedge clk);
    cyc = 1; seen = 1'b0; dones = 0; busy_after = 0; res = -1; er = -1; lat = -1;
    if (!hold_start) start = 1'b0;
    while (!seen && cyc < 4000) begin
      if (done) begin
        seen = 1'b1; lat = cyc; res = int'(result); er = int'(err); dones = 1;
      end else begin
        base = 8'($urandom); exponent = 8'($urandom); modulus = 8'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
      if (busy) busy_after++;
    end
    jobs = mm_pulses - p0;
  endtask

  task automatic do_op(input string tag, input int b, input int e, input int n,
                       input bit hold_start, input int want_res, input int want_err);
    int res, er, lat, jobs, dones, busy_after, ref_r, ref_e;
    bit fast;
    ref_r = ref_exp(b, e, n, ref_e);
    if (want_res >= 0) check({tag, "_ref"}, ref_r, want_res);
    fast = (ref_e != 0) || (n == 1) || (e == 0);
    run_op(b, e, n, hold_start, res, er, lat, jobs, dones, busy_after);
    check({tag, "_result"}, res, ref_r);
    check({tag, "_err"}, er, (want_err >= 0) ? want_err : ref_e);
    check({tag, "_jobs"}, jobs, fast ? 0 : 8 + $countones(8'(e)));
    check({tag, "_dones"}, dones, 1);
    check({tag, "_idle_after"}, busy_after, 0);
    if (fast) check({tag, "_latency"}, lat, 2);
    else if (lat < 0) check({tag, "_timeout"}, lat, 0);
  endtask

  initial begin
    int n, b, e, guard;
    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_result", int'(result), 0);
    check("rst_mm_start", int'(mm_start), 0);
    check("rst_mm_a", int'(mm_a), 0);
    check("rst_mm_n", int'(mm_n), 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("t1", 4, 5, 13, 1'b0, 10, 0);
    do_op("t2", 7, 8'hFF, 11, 1'b0, 10, 0);
    fixed_lat = 3;
    do_op("t2_lat3", 7, 8'hFF, 11, 1'b0, 10, 0);
    fixed_lat = 40;
    do_op("t2_lat40", 7, 8'hFF, 11, 1'b0, 10, 0);
    fixed_lat = 0;

    do_op("fast_exp0", 5, 0, 13, 1'b0, 1, 0);
    do_op("fast_n1", 0, 9, 1, 1'b0, 0, 0);
    do_op("fast_n0", 3, 9, 0, 1'b0, 0, 1);
    do_op("fast_big", 20, 9, 13, 1'b0, 0, 1);

    stale_mode = 1'b1;
    do_op("stale", 2, 3, 13, 1'b0, 8, 0);
    stale_mode = 1'b0;

    do_op("hold_start", 4, 5, 13, 1'b1, 10, 0);

    for (int k = 0; k < 20; k++) begin
      n = (k % 5 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 255));
      b = (k % 7 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, (n > 0) ? n - 1 : 0));
      e = int'($urandom_range(0, 255));
      do_op("rand", b, e, n, 1'(k % 4 == 1), -1, -1);
    end

    // Reset while a multiply job is outstanding.
    @(negedge clk);
    start = 1'b1; base = 8'd4; exponent = 8'd5; modulus = 8'd13;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(mm_start && (mm_a != mm_b)) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("mu_job_seen", int'(guard < 4000), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_mm_start", int'(mm_start), 0);
    check("midrst_result", int'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 3, 6, 7, 1'b0, 1, 0);

    check("overlapping_jobs", overlaps, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
